// File: rtl/stack_pkg.sv
// Shared definitions for the stack program sequencer: opcodes, error codes,
// instruction word layout {halt, opcode[2:0], operand[WIDTH-1:0]} and FSM states.
package stack_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_PUSH = 3'd6;
  localparam logic [2:0] OP_POP  = 3'd7;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_OVF    = 2'd1;
  localparam logic [1:0] ERR_UNF    = 2'd2;
  localparam logic [1:0] ERR_NOHALT = 2'd3;

  // Control bits above the operand: one halt flag plus the opcode field.
  localparam int OPC_W  = 3;
  localparam int CTRL_W = 4;

  // Bit position of the halt flag for a given operand width.
  function automatic int halt_pos(input int width);
    return width + 3;
  endfunction

  // Least significant bit of the opcode field for a given operand width.
  function automatic int opc_lsb(input int width);
    return width;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

endpackage

// File: rtl/stack_prog_mem.sv
// Program memory: register array with a synchronous write port and an
// asynchronous read port so FETCH can decode the word in the same cycle.
module stack_prog_mem #(
  parameter int DEPTH = 16,
  parameter int IW    = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem_r [DEPTH];

  // Write one program word when enabled; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/stack_program_sequencer.sv
// Issues a stored program of stack instructions to the stack ALU, one opcode
// per instruction, with depth pre-checks, overflow detection and sticky errors.
module stack_program_sequencer
  import stack_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int STACK_DEPTH = 8,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_en,
  input  logic [AW-1:0]       load_addr,
  input  logic [4+WIDTH-1:0]  load_data,
  input  logic                start,
  output logic [WIDTH-1:0]    stk_in,
  output logic [2:0]          stk_opcode,
  input  logic [WIDTH-1:0]    stk_out,
  input  logic                stk_overflow,
  input  logic [7:0]          stk_index,
  output logic                busy,
  output logic                done,
  output logic [1:0]          error,
  output logic [WIDTH-1:0]    result,
  output logic [AW-1:0]       pc
);

  localparam int IW       = CTRL_W + WIDTH;
  localparam int HALT_BIT = halt_pos(WIDTH);
  localparam int OPC_LSB  = opc_lsb(WIDTH);

  state_t             state_r, state_s;
  logic [AW-1:0]      pc_r, pc_s;
  logic [1:0]         error_r, error_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic [WIDTH-1:0]   result_r, result_s;
  logic [2:0]         opcode_r, opcode_s;
  logic [WIDTH-1:0]   operand_r, operand_s;

  logic               mem_we_s;
  logic [IW-1:0]      rd_word_s;
  logic               word_halt_s;
  logic [2:0]         word_opc_s;
  logic [WIDTH-1:0]   word_arg_s;

  // Loads are only accepted while no program is running.
  assign mem_we_s = load_en & ~busy_r;

  stack_prog_mem #(
    .DEPTH (DEPTH),
    .IW    (IW),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_r),
    .rdata (rd_word_s)
  );

  assign word_halt_s = rd_word_s[HALT_BIT];
  assign word_opc_s  = rd_word_s[OPC_LSB +: OPC_W];
  assign word_arg_s  = rd_word_s[WIDTH-1:0];

  // State and all outputs are registered; synchronous reset returns them to idle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      pc_r      <= '0;
      error_r   <= ERR_NONE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= '0;
      opcode_r  <= OP_NOP;
      operand_r <= '0;
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      error_r   <= error_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      result_r  <= result_s;
      opcode_r  <= opcode_s;
      operand_r <= operand_s;
    end
  end

  // Next-state and next-output decode; opcode/operand are only loaded on the way into ISSUE.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    error_s   = error_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    result_s  = result_r;
    opcode_s  = OP_NOP;
    operand_s = '0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          error_s = ERR_NONE;
          pc_s    = '0;
          busy_s  = 1'b1;
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (word_halt_s) begin
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = ST_DONE;
        end else if ((word_opc_s == OP_PUSH) && (stk_index == 8'(STACK_DEPTH))) begin
          error_s = ERR_OVF;
          busy_s  = 1'b0;
          state_s = ST_ERROR;
        end else if (((word_opc_s == OP_POP) && (stk_index == 8'd0)) ||
                     (((word_opc_s == OP_ADD) || (word_opc_s == OP_MUL)) && (stk_index < 8'd2))) begin
          error_s = ERR_UNF;
          busy_s  = 1'b0;
          state_s = ST_ERROR;
        end else begin
          opcode_s  = word_opc_s;
          operand_s = word_arg_s;
          state_s   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_CHECK;
      end
      ST_CHECK: begin
        result_s = stk_out;
        if (stk_overflow) begin
          error_s = ERR_OVF;
          busy_s  = 1'b0;
          state_s = ST_ERROR;
        end else if (pc_r == AW'(DEPTH - 1)) begin
          error_s = ERR_NOHALT;
          busy_s  = 1'b0;
          state_s = ST_ERROR;
        end else begin
          pc_s    = pc_r + AW'(1);
          state_s = ST_FETCH;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      ST_ERROR: begin
        state_s = ST_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  assign stk_in     = operand_r;
  assign stk_opcode = opcode_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;
  assign result     = result_r;
  assign pc         = pc_r;

endmodule

// File: tb/tb_stack_program_sequencer.sv
// Directed bench for stack_program_sequencer with a small behavioural stack ALU.
module tb_stack_program_sequencer;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [11:0] load_data;
  logic        start;
  logic [7:0]  stk_in;
  logic [2:0]  stk_opcode;
  logic [7:0]  stk_out;
  logic        stk_overflow;
  logic [7:0]  stk_index;
  logic        busy;
  logic        done;
  logic [1:0]  error;
  logic [7:0]  result;
  logic [3:0]  pc;

  int checks;
  int errors;

  stack_program_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .start        (start),
    .stk_in       (stk_in),
    .stk_opcode   (stk_opcode),
    .stk_out      (stk_out),
    .stk_overflow (stk_overflow),
    .stk_index    (stk_index),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .result       (result),
    .pc           (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8-deep stack ALU reacting to the issued opcode.
  logic [7:0] sm [8];
  int         cnt;
  logic       ovf;

  always @(posedge clk) begin
    if (rst) begin
      cnt <= 0;
      ovf <= 1'b0;
    end else begin
      case (stk_opcode)
        3'd6: begin
          if (cnt == 8) ovf <= 1'b1;
          else begin sm[cnt] <= stk_in; cnt <= cnt + 1; ovf <= 1'b0; end
        end
        3'd7: if (cnt != 0) cnt <= cnt - 1;
        3'd4: if (cnt >= 2) begin sm[cnt-2] <= sm[cnt-2] + sm[cnt-1]; cnt <= cnt - 1; end
        3'd5: if (cnt >= 2) begin sm[cnt-2] <= 8'(sm[cnt-2] * sm[cnt-1]); cnt <= cnt - 1; end
        default: ;
      endcase
    end
  end

  assign stk_out      = (cnt == 0) ? 8'd0 : sm[cnt-1];
  assign stk_index    = 8'(cnt);
  assign stk_overflow = ovf;

  // Monitor: log every non-NOP issue and count done/busy cycles.
  logic [2:0] op_q[$];
  logic [7:0] arg_q[$];
  int         done_cnt;
  int         busy_cnt;

  always @(negedge clk) begin
    if (stk_opcode != 3'd0) begin
      op_q.push_back(stk_opcode);
      arg_q.push_back(stk_in);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  function automatic logic [11:0] w(input logic h, input logic [2:0] op, input logic [7:0] v);
    return {h, op, v};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic clr_mon();
    @(posedge clk);
    done_cnt = 0;
    busy_cnt = 0;
    op_q.delete();
    arg_q.delete();
    @(negedge clk);
  endtask

  task automatic load_word(input int a, input logic [11:0] d);
    load_en   = 1'b1;
    load_addr = 4'(a);
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  // Wait (bounded) for busy to drop, then let DONE/ERROR return to IDLE.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s timeout: busy still %0b, required 0", name, busy);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_prog(input string name);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(name);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (stk_opcode !== 3'd0) begin errors++; $display("FAIL reset_opcode got %0d exp 0", stk_opcode); end
    checks++; if (stk_in !== 8'd0) begin errors++; $display("FAIL reset_in got %0d exp 0", stk_in); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got %b exp 00", {busy, done}); end
    checks++; if (error !== 2'd0) begin errors++; $display("FAIL reset_error got %0d exp 0", error); end
    checks++; if (result !== 8'd0) begin errors++; $display("FAIL reset_result got %0d exp 0", result); end
    checks++; if (pc !== 4'd0) begin errors++; $display("FAIL reset_pc got %0d exp 0", pc); end
  endtask

  task automatic test_add();
    do_reset();
    load_word(0, w(1'b0, 3'd6, 8'd1));
    load_word(1, w(1'b0, 3'd6, 8'd2));
    load_word(2, w(1'b0, 3'd4, 8'd0));
    load_word(3, w(1'b1, 3'd0, 8'd0));
    clr_mon();
    run_prog("add");
    checks++;
    if (op_q.size() !== 3) begin errors++; $display("FAIL add_issue_count got %0d exp 3", op_q.size()); end
    else if (op_q[0] !== 3'd6 || op_q[1] !== 3'd6 || op_q[2] !== 3'd4 || arg_q[0] !== 8'd1 || arg_q[1] !== 8'd2 || arg_q[2] !== 8'd0) begin
      errors++; $display("FAIL add_issue_seq got %0d/%0d %0d/%0d %0d/%0d exp 6/1 6/2 4/0", op_q[0], arg_q[0], op_q[1], arg_q[1], op_q[2], arg_q[2]);
    end
    checks++; if (result !== 8'd3) begin errors++; $display("FAIL add_result got %0d exp 3", result); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL add_done got %0d exp 1", done_cnt); end
    checks++; if (error !== 2'd0) begin errors++; $display("FAIL add_error got %0d exp 0", error); end
    checks++; if (pc !== 4'd3) begin errors++; $display("FAIL add_pc got %0d exp 3", pc); end
    checks++; if (busy_cnt !== 10) begin errors++; $display("FAIL add_busy_cycles got %0d exp 10", busy_cnt); end
  endtask

  task automatic test_mul();
    do_reset();
    load_word(0, w(1'b0, 3'd6, 8'd20));
    load_word(1, w(1'b0, 3'd6, 8'd13));
    load_word(2, w(1'b0, 3'd5, 8'd0));
    load_word(3, w(1'b1, 3'd0, 8'd0));
    clr_mon();
    run_prog("mul");
    checks++; if (result !== 8'd4) begin errors++; $display("FAIL mul_result got %0d exp 4", result); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL mul_done got %0d exp 1", done_cnt); end
    checks++; if (error !== 2'd0) begin errors++; $display("FAIL mul_error got %0d exp 0", error); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) load_word(i, w(1'b0, 3'd6, 8'(i + 1)));
    load_word(9, w(1'b1, 3'd0, 8'd0));
    clr_mon();
    run_prog("ovf");
    checks++; if (op_q.size() !== 8) begin errors++; $display("FAIL ovf_issue_count got %0d exp 8", op_q.size()); end
    checks++; if (error !== 2'd1) begin errors++; $display("FAIL ovf_error got %0d exp 1", error); end
    checks++; if (pc !== 4'd8) begin errors++; $display("FAIL ovf_pc got %0d exp 8", pc); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL ovf_done got %0d exp 0", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy got %0b exp 0", busy); end
    checks++; if (result !== 8'd8) begin errors++; $display("FAIL ovf_result got %0d exp 8", result); end
  endtask

  task automatic test_underflow();
    do_reset();
    load_word(0, w(1'b0, 3'd6, 8'd5));
    load_word(1, w(1'b0, 3'd4, 8'd0));
    load_word(2, w(1'b1, 3'd0, 8'd0));
    clr_mon();
    run_prog("unf");
    checks++; if (op_q.size() !== 1 || op_q[0] !== 3'd6) begin errors++; $display("FAIL unf_issue got count %0d exp 1 (PUSH only)", op_q.size()); end
    checks++; if (error !== 2'd2) begin errors++; $display("FAIL unf_error got %0d exp 2", error); end
    checks++; if (pc !== 4'd1) begin errors++; $display("FAIL unf_pc got %0d exp 1", pc); end
    checks++; if (result !== 8'd5) begin errors++; $display("FAIL unf_result got %0d exp 5", result); end
  endtask

  task automatic test_nohalt();
    do_reset();
    for (int i = 0; i < 16; i += 2) begin
      load_word(i, w(1'b0, 3'd6, 8'(i + 10)));
      load_word(i + 1, w(1'b0, 3'd7, 8'd0));
    end
    clr_mon();
    run_prog("nohalt");
    checks++; if (error !== 2'd3) begin errors++; $display("FAIL nohalt_error got %0d exp 3", error); end
    checks++; if (pc !== 4'd15) begin errors++; $display("FAIL nohalt_pc got %0d exp 15", pc); end
    checks++; if (op_q.size() !== 16) begin errors++; $display("FAIL nohalt_issue_count got %0d exp 16", op_q.size()); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL nohalt_done got %0d exp 0", done_cnt); end
  endtask

  task automatic test_rst_mid();
    int n;
    do_reset();
    load_word(0, w(1'b0, 3'd6, 8'd1));
    load_word(1, w(1'b0, 3'd6, 8'd2));
    load_word(2, w(1'b0, 3'd4, 8'd0));
    load_word(3, w(1'b1, 3'd0, 8'd0));
    clr_mon();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(stk_opcode == 3'd6 && pc == 4'd1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(stk_opcode == 3'd6 && pc == 4'd1)) begin errors++; $display("FAIL rst_mid_find_issue got op %0d pc %0d exp op 6 pc 1", stk_opcode, pc); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (stk_opcode !== 3'd0) begin errors++; $display("FAIL rst_mid_opcode got %0d exp 0", stk_opcode); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %0b exp 0", busy); end
    checks++; if (pc !== 4'd0) begin errors++; $display("FAIL rst_mid_pc got %0d exp 0", pc); end
    checks++; if (error !== 2'd0) begin errors++; $display("FAIL rst_mid_error got %0d exp 0", error); end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (op_q.size() !== 2) begin errors++; $display("FAIL rst_mid_no_more_issue got %0d exp 2", op_q.size()); end
    clr_mon();
    run_prog("rerun");
    checks++; if (result !== 8'd3) begin errors++; $display("FAIL rerun_result got %0d exp 3", result); end
    checks++; if (done_cnt !== 1 || op_q.size() !== 3) begin errors++; $display("FAIL rerun_done_issue got done %0d issues %0d exp 1 3", done_cnt, op_q.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    clr_mon();
    // Memory still holds PUSH 1, PUSH 2, ADD, HALT: overwrite word 0 in the start cycle.
    load_en   = 1'b1;
    load_addr = 4'd0;
    load_data = w(1'b0, 3'd6, 8'd7);
    start     = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    start   = 1'b0;
    @(negedge clk);
    // Load and start while busy must both be ignored.
    load_en   = 1'b1;
    load_addr = 4'd3;
    load_data = w(1'b0, 3'd6, 8'd9);
    start     = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    start   = 1'b0;
    wait_idle("b2b");
    checks++; if (op_q.size() !== 3 || arg_q[0] !== 8'd7) begin errors++; $display("FAIL b2b_first_word got count %0d arg0 %0d exp 3 7", op_q.size(), arg_q[0]); end
    checks++; if (result !== 8'd9) begin errors++; $display("FAIL b2b_result got %0d exp 9", result); end
    checks++; if (done_cnt !== 1 || pc !== 4'd3) begin errors++; $display("FAIL b2b_done_pc got done %0d pc %0d exp 1 3", done_cnt, pc); end
    checks++; if (busy_cnt !== 10) begin errors++; $display("FAIL b2b_busy_cycles got %0d exp 10", busy_cnt); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    done_cnt  = 0;
    busy_cnt  = 0;
    rst       = 1'b1;
    load_en   = 1'b0;
    load_addr = 4'd0;
    load_data = 12'd0;
    start     = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_mul();
    test_overflow();
    test_underflow();
    test_nohalt();
    test_rst_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
